// File: rtl/rx_i2s.sv
// I2S receiver: decodes an externally clocked bclk/lrck/sdata stream and emits
// left/right words as MSB-first bytes into the capture FIFO.
module rx_i2s #(
   parameter int TIMEOUT_CLKS = 256
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [1:0] bit_depth_i,
   input  logic       bclk_i,
   input  logic       lrck_i,
   input  logic       sdata_i,
   output logic       wr_input_FIFO_en_o,
   output logic [7:0] wr_input_FIFO_data_o,
   input  logic       wr_input_FIFO_full_i,
   output logic       input_streaming_o,
   output logic       overrun_o,
   output logic       slot_error_o
);

   localparam logic [1:0] BIT_DEPTH_16  = 2'd0;
   localparam logic [1:0] BIT_DEPTH_24  = 2'd1;
   localparam logic [1:0] BIT_DEPTH_DOP = 2'd2;
   localparam logic [1:0] BIT_DEPTH_32  = 2'd3;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t        state;
   state_t        state_next;
   logic [2:0]    bclk_sync;
   logic [1:0]    lrck_sync;
   logic [1:0]    sdata_sync;
   logic          rise;
   logic          lr;
   logic          sd;
   logic          lrck_prev;
   logic          boundary;
   logic [5:0]    depth;
   logic [5:0]    depth_sel;
   logic [5:0]    bitcnt;
   logic [5:0]    count_incl;
   logic [31:0]   shreg;
   logic [31:0]   word_full;
   logic [31:0]   word_aligned;
   logic [31:0]   hold;
   logic [2:0]    bytes_left;
   logic [TW-1:0] idle_cnt;
   logic          timeout;
   logic          capture;
   logic          short_slot;
   logic          emit_word;
   logic          pending;
   logic          last_byte;
   logic          accept;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         bclk_sync  <= '0;
         lrck_sync  <= '0;
         sdata_sync <= '0;
      end else begin
         bclk_sync  <= {bclk_sync[1:0], bclk_i};
         lrck_sync  <= {lrck_sync[0], lrck_i};
         sdata_sync <= {sdata_sync[0], sdata_i};
      end
   end

   assign rise     = bclk_sync[1] & ~bclk_sync[2];
   assign lr       = lrck_sync[1];
   assign sd       = sdata_sync[1];
   assign boundary = rise & (lr != lrck_prev);

   always_comb begin
      depth_sel = 6'd16;
      case (bit_depth_i)
         BIT_DEPTH_16:  depth_sel = 6'd16;
         BIT_DEPTH_24:  depth_sel = 6'd24;
         BIT_DEPTH_DOP: depth_sel = 6'd24;
         BIT_DEPTH_32:  depth_sel = 6'd32;
         default:       depth_sel = 6'd16;
      endcase
   end

   // The boundary bit is the LSB of the slot that is ending, so it joins the word.
   assign count_incl   = (bitcnt < depth) ? bitcnt + 6'd1 : bitcnt;
   assign word_full    = (bitcnt < depth) ? {shreg[30:0], sd} : shreg;
   assign word_aligned = word_full << (6'd32 - depth);
   assign capture      = boundary & (count_incl == depth);
   assign short_slot   = boundary & (count_incl != depth);
   assign timeout      = (state == STREAM) & ~rise & (idle_cnt == TW'(TIMEOUT_CLKS - 1));
   assign emit_word    = capture & (state == STREAM);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         idle_cnt <= '0;
      end else if (rise) begin
         idle_cnt <= '0;
      end else if (idle_cnt != TW'(TIMEOUT_CLKS)) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Alignment waits for a right-to-left change so the first word emitted is always a left word.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (boundary && lrck_prev && !lr) state_next = STREAM;
         STREAM:  if (timeout) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         depth <= 6'd16;
      end else if (state == IDLE) begin
         depth <= depth_sel;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         shreg     <= '0;
         bitcnt    <= '0;
         lrck_prev <= 1'b0;
      end else if (timeout) begin
         shreg  <= '0;
         bitcnt <= '0;
      end else if (rise) begin
         lrck_prev <= lr;
         if (bitcnt < depth) shreg <= {shreg[30:0], sd};
         if (boundary) begin
            bitcnt <= '0;
         end else if (bitcnt < depth) begin
            bitcnt <= bitcnt + 6'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         slot_error_o <= 1'b0;
      end else begin
         slot_error_o <= short_slot & (state == STREAM);
      end
   end

   assign pending              = (bytes_left != 3'd0);
   assign wr_input_FIFO_en_o   = pending & ~wr_input_FIFO_full_i;
   assign wr_input_FIFO_data_o = hold[31:24];
   assign last_byte            = wr_input_FIFO_en_o & (bytes_left == 3'd1);
   assign accept               = emit_word & (~pending | last_byte);

   // The holding register stays left-aligned so the next byte is always the top byte.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hold       <= '0;
         bytes_left <= '0;
      end else if (timeout) begin
         hold       <= '0;
         bytes_left <= '0;
      end else if (accept) begin
         hold       <= word_aligned;
         bytes_left <= depth[5:3];
      end else if (wr_input_FIFO_en_o) begin
         hold       <= hold << 8;
         bytes_left <= bytes_left - 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         overrun_o <= 1'b0;
      end else if (state == IDLE && state_next == STREAM) begin
         overrun_o <= 1'b0;
      end else if (emit_word && !accept) begin
         overrun_o <= 1'b1;
      end
   end

   assign input_streaming_o = (state == STREAM);

endmodule

// File: tb/tb_rx_i2s.sv
// Directed bench for rx_i2s: drives I2S slots and checks emitted bytes against a
// slot-level model of which words must appear, plus literal byte lists per scenario.
module tb_rx_i2s;

   localparam int TIMEOUT = 256;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] bit_depth;
   logic       bclk;
   logic       lrck;
   logic       sdata;
   logic       full;
   logic       en;
   logic [7:0] data;
   logic       streaming;
   logic       overrun;
   logic       slot_error;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]  exp_q[$];
   logic [7:0]  log_q[$];
   logic [7:0]  want[$];
   int          model_depth  = 16;
   bit          aligned      = 1'b0;
   bit          pend_valid   = 1'b0;
   bit          full_hold    = 1'b0;
   bit          word_held    = 1'b0;
   bit          exp_overrun  = 1'b0;
   int          prev_ch      = 0;
   int          pend_w       = 0;
   logic [31:0] pend_val     = '0;
   int          exp_slot_err = 0;
   int          seen_slot_err = 0;
   int          err_base     = 0;
   logic        prev_d       = 1'b0;

   rx_i2s #(.TIMEOUT_CLKS(TIMEOUT)) dut (
      .clk_i                (clk),
      .reset_n_i            (reset_n),
      .bit_depth_i          (bit_depth),
      .bclk_i               (bclk),
      .lrck_i               (lrck),
      .sdata_i              (sdata),
      .wr_input_FIFO_en_o   (en),
      .wr_input_FIFO_data_o (data),
      .wr_input_FIFO_full_i (full),
      .input_streaming_o    (streaming),
      .overrun_o            (overrun),
      .slot_error_o         (slot_error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Every byte the DUT writes is checked against the model queue as it happens.
   always @(negedge clk) begin
      if (reset_n) begin
         if (slot_error) seen_slot_err++;
         if (full) checkOutput("en_while_full", {31'd0, en}, 32'd0);
         if (en) begin
            log_q.push_back(data);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", data);
            end else begin
               checkOutput("byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   // A slot starting on a new channel completes the previous slot.
   task automatic start_slot(input int ch);
      logic [31:0] word;
      if (ch != prev_ch && pend_valid && aligned) begin
         if (pend_w < model_depth) begin
            exp_slot_err++;
         end else if (full_hold && word_held) begin
            exp_overrun = 1'b1;
         end else begin
            word = pend_val >> (pend_w - model_depth);
            for (int b = model_depth / 8 - 1; b >= 0; b--) exp_q.push_back(8'(word >> (8 * b)));
            if (full_hold) word_held = 1'b1;
         end
      end
      if (!aligned && prev_ch == 1 && ch == 0) aligned = 1'b1;
      prev_ch = ch;
   endtask

   task automatic drive_bit(input logic lr, input logic d);
      bclk  = 1'b0;
      lrck  = lr;
      sdata = prev_d;
      prev_d = d;
      #40;
      bclk = 1'b1;
      #40;
   endtask

   task automatic applyStimulus(input int ch, input logic [31:0] val, input int w);
      start_slot(ch);
      pend_val   = val;
      pend_w     = w;
      pend_valid = 1'b1;
      for (int i = w - 1; i >= 0; i--) drive_bit(ch[0], val[i]);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_full(input logic v);
      @(posedge clk);
      #1 full = v;
      full_hold = v;
      if (!v) word_held = 1'b0;
   endtask

   task automatic stop_stream(input string name);
      wait_clks(TIMEOUT - 40);
      checkOutput({name, "_streaming_before_timeout"}, {31'd0, streaming}, 32'd1);
      wait_clks(60);
      checkOutput({name, "_streaming_after_timeout"}, {31'd0, streaming}, 32'd0);
      aligned    = 1'b0;
      pend_valid = 1'b0;
      word_held  = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_log(input string name);
      checkOutput({name, "_count"}, log_q.size(), want.size());
      for (int i = 0; i < want.size(); i++)
         if (i < log_q.size()) checkOutput(name, {24'd0, log_q[i]}, {24'd0, want[i]});
   endtask

   task automatic check_reset_outputs(input string name);
      checkOutput({name, "_en"}, {31'd0, en}, 32'd0);
      checkOutput({name, "_data"}, {24'd0, data}, 32'd0);
      checkOutput({name, "_streaming"}, {31'd0, streaming}, 32'd0);
      checkOutput({name, "_overrun"}, {31'd0, overrun}, 32'd0);
      checkOutput({name, "_slot_error"}, {31'd0, slot_error}, 32'd0);
   endtask

   task automatic end_test(input string name);
      checkOutput({name, "_drained"}, exp_q.size(), 32'd0);
      checkOutput({name, "_slot_errors"}, seen_slot_err, exp_slot_err);
   endtask

   initial begin
      reset_n = 1'b0; bclk = 1'b0; lrck = 1'b0; sdata = 1'b0;
      full = 1'b0; bit_depth = 2'd0;
      wait_clks(3);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 reset_n = 1'b1;
      wait_clks(5);

      // 16-bit words in 32-bit slots
      log_q.delete(); bit_depth = 2'd0; model_depth = 16;
      applyStimulus(1, 32'h0000_0000, 32);
      applyStimulus(0, 32'hA55A_0000, 32);
      applyStimulus(1, 32'h1234_0000, 32);
      applyStimulus(0, 32'h0000_0000, 32);
      checkOutput("t1_streaming", {31'd0, streaming}, 32'd1);
      want = '{8'hA5, 8'h5A, 8'h12, 8'h34};
      check_log("t1_bytes");
      end_test("t1");
      stop_stream("t1");

      // 24-bit words in 24-bit slots
      log_q.delete(); bit_depth = 2'd1; model_depth = 24;
      applyStimulus(1, 32'h0000_0000, 24);
      applyStimulus(0, 32'h0012_3456, 24);
      applyStimulus(1, 32'h00AB_CDEF, 24);
      applyStimulus(0, 32'h0000_0000, 24);
      want = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
      check_log("t2_bytes");
      end_test("t2");
      stop_stream("t2");

      // 32-bit words; a depth change mid-stream must be ignored
      log_q.delete(); bit_depth = 2'd3; model_depth = 32;
      applyStimulus(1, 32'h0000_0000, 32);
      applyStimulus(0, 32'hDEAD_BEEF, 32);
      bit_depth = 2'd0;
      applyStimulus(1, 32'h0000_0000, 32);
      want = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      check_log("t3_bytes");
      end_test("t3");
      stop_stream("t3");

      // 16-bit depth truncating 32-bit slots
      log_q.delete(); bit_depth = 2'd0; model_depth = 16;
      applyStimulus(1, 32'h0000_0000, 32);
      applyStimulus(0, 32'hCAFE_0001, 32);
      applyStimulus(1, 32'h0000_0000, 32);
      want = '{8'hCA, 8'hFE};
      check_log("t4_bytes");
      end_test("t4");
      stop_stream("t4");

      // Right-slot start, then a 12-bit slot at 16-bit depth
      log_q.delete(); err_base = seen_slot_err;
      applyStimulus(1, 32'h0000_7777, 16);
      checkOutput("t5_no_bytes_before_left", log_q.size(), 32'd0);
      applyStimulus(0, 32'h0000_1111, 16);
      applyStimulus(1, 32'h0000_0ABC, 12);
      applyStimulus(0, 32'h0000_2222, 16);
      applyStimulus(1, 32'h0000_3333, 16);
      applyStimulus(0, 32'h0000_0000, 16);
      want = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
      check_log("t5_bytes");
      checkOutput("t5_one_slot_error", seen_slot_err - err_base, 32'd1);
      end_test("t5");
      stop_stream("t5");

      // Overrun: full held across two captures, only the first word survives
      log_q.delete();
      set_full(1'b1);
      applyStimulus(1, 32'h0000_5555, 16);
      applyStimulus(0, 32'h0000_BEEF, 16);
      applyStimulus(1, 32'h0000_0F0F, 16);
      applyStimulus(0, 32'h0000_1357, 16);
      checkOutput("t6_no_bytes_while_full", log_q.size(), 32'd0);
      checkOutput("t6_overrun", {31'd0, overrun}, {31'd0, exp_overrun});
      checkOutput("t6_overrun_literal", {31'd0, overrun}, 32'd1);
      set_full(1'b0);
      wait_clks(20);
      want = '{8'hBE, 8'hEF};
      check_log("t6_bytes");
      end_test("t6");
      stop_stream("t6");
      checkOutput("t6_overrun_sticky", {31'd0, overrun}, 32'd1);

      // Timeout drops a held word; entering the stream clears overrun
      log_q.delete(); exp_overrun = 1'b0;
      set_full(1'b1);
      applyStimulus(1, 32'h0000_0000, 16);
      applyStimulus(0, 32'h0000_4242, 16);
      applyStimulus(1, 32'h0000_0000, 16);
      checkOutput("t7_overrun_cleared", {31'd0, overrun}, 32'd0);
      stop_stream("t7");
      set_full(1'b0);
      wait_clks(20);
      want.delete();
      check_log("t7_bytes");
      end_test("t7");

      // Reset mid-word, then re-align on the left channel
      log_q.delete();
      applyStimulus(1, 32'h0000_0000, 16);
      applyStimulus(0, 32'h0000_6666, 16);
      start_slot(1);
      pend_valid = 1'b0;
      for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1);
      wait_clks(10);
      @(posedge clk);
      #1 reset_n = 1'b0;
      wait_clks(3);
      check_reset_outputs("t8_reset");
      aligned = 1'b0; pend_valid = 1'b0; prev_ch = 0; word_held = 1'b0;
      exp_overrun = 1'b0; exp_q.delete();
      @(posedge clk);
      #1 reset_n = 1'b1;
      wait_clks(5);
      applyStimulus(1, 32'h0000_7777, 16);
      applyStimulus(0, 32'h0000_8888, 16);
      applyStimulus(1, 32'h0000_9999, 16);
      applyStimulus(0, 32'h0000_0000, 16);
      checkOutput("t8_streaming", {31'd0, streaming}, 32'd1);
      want = '{8'h66, 8'h66, 8'h88, 8'h88, 8'h99, 8'h99};
      check_log("t8_bytes");
      end_test("t8");
      stop_stream("t8");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rx_i2s.md
# rx_i2s

I2S receiver that decodes an external I2S stream into a byte stream for the capture path. It samples an externally mastered bclk/lrck/sdata triplet on the single system clock, extracts left and right words of the configured bit depth, and writes them MSB-first, left then right, into the input FIFO. This is the same byte format the playback path consumes.

## Interface

Parameters:
- `TIMEOUT_CLKS`, default 256: `clk_i` cycles with no bclk rising edge before the stream is declared stopped.

Ports:
- `clk_i` input 1: system clock. Must be at least 4× the bclk frequency.
- `reset_n_i` input 1: asynchronous, active-low reset.
- `bit_depth_i` input 2: uses the `BIT_DEPTH_16/24/DOP/32` encodings from definitions.svh. DOP is handled exactly like 24.
- `bclk_i` input 1: I2S bit clock. Asynchronous to `clk_i`.
- `lrck_i` input 1: I2S word select. 0 = left, 1 = right.
- `sdata_i` input 1: I2S serial data.
- `wr_input_FIFO_en_o` output 1: byte write strobe.
- `wr_input_FIFO_data_o` output 8: byte to write.
- `wr_input_FIFO_full_i` input 1: FIFO full.
- `input_streaming_o` output 1: high while a stream is being received.
- `overrun_o` output 1: sticky flag. A word was dropped because the emitter was busy.
- `slot_error_o` output 1: one-cycle pulse. A slot was shorter than the bit depth.

## Operation

**Synchronisation**
- `bclk_i`, `lrck_i` and `sdata_i` each pass through a 2-FF synchronizer.
- A third `bclk` stage provides rising-edge detection (`rise`).
- All decode logic advances only on a `rise` cycle.

**Decode, per `rise`**
- `lrck_prev` holds `lrck` as sampled at the previous `rise`.
- Boundary condition: `lrck != lrck_prev`. Under I2S one-bit delay, the bit sampled at the boundary `rise` is the last bit of the old slot.
- The shift register takes `sdata` while `bitcnt < depth`; `depth` is 16, 24 or 32.
- `bitcnt` saturates at `depth`.
- At the boundary, the word is completed using that bit:
  - If `bitcnt` (including the boundary bit) equals `depth`, the word is captured for channel `lrck_prev`.
  - Otherwise `slot_error_o` pulses and the word is discarded.
- At the boundary, `bitcnt` is then cleared, so the next `rise` captures the MSB.
- Slot bits beyond `depth` are ignored. A 32-bit slot therefore truncates to the top `depth` bits.

**State machine**
- IDLE:
  - `depth` is latched from `bit_depth_i` continuously.
  - Words are not emitted.
  - The first boundary where `lrck` goes 1→0 moves to STREAM. Alignment always starts on a left word.
  - On entering STREAM, `overrun_o` is cleared.
- STREAM:
  - `depth` is frozen; `bit_depth_i` changes are ignored until IDLE.
  - `input_streaming_o` = 1.
  - Every captured word goes to the emitter.
- STREAM → IDLE: `TIMEOUT_CLKS` consecutive cycles without `rise`. The shift register, `bitcnt` and emitter are flushed, and any pending word is discarded.

**Emitter**
- One holding register plus a byte index.
- Byte order per word: most significant byte first.
- Bytes per word: `depth`/8, i.e. 2, 3 or 4.
- If a word is captured while the emitter is still busy, the new word is dropped and `overrun_o` is set.

## Timing

- Reset values:
  - `wr_input_FIFO_en_o` = 0
  - `wr_input_FIFO_data_o` = 0
  - `input_streaming_o` = 0
  - `overrun_o` = 0
  - `slot_error_o` = 0
  - Internal state: IDLE, `bitcnt` = 0, emitter empty.
- Pin to `rise`: 3 `clk_i` cycles.
- Word capture is registered on the boundary `rise` cycle. The first byte is presented on the next cycle.
- `wr_input_FIFO_en_o` = `pending & ~wr_input_FIFO_full_i`. This path is combinational on `full`.
  - Data is valid whenever `en` is high.
  - The byte index advances only on a cycle where `en` is high.
  - With `full` held high, data is held and nothing is written.
- At most one byte per `clk_i`. A word drains in `depth`/8 cycles when not stalled.
- A simultaneous new capture and the last byte (`en` high) of the previous word is accepted, not an overrun.
- `input_streaming_o`:
  - Rises the cycle after the aligning boundary.
  - Falls on the timeout cycle.
- Asserting `reset_n_i` mid-word discards the partial word. After release, the block re-aligns on the next 1→0 `lrck` boundary.

## Test plan

- **16-bit, 32-bit slots, bclk = clk/8.** Send L=0xA55A, R=0x1234 → bytes A5,5A,12,34; `input_streaming_o`=1.
- **24-bit, then 32-bit.** At 24-bit, L=0x123456, R=0xABCDEF → 12,34,56,AB,CD,EF. At 32-bit, L=0xDEADBEEF → DE,AD,BE,EF.
- **Truncation.** 16-bit depth with 32-bit slots carrying 0xCAFE0001 → bytes CA,FE only.
- **Start on right slot, then short slot.**
  - Stream starts with a right slot → no bytes until after the first left slot completes.
  - A 12-bit slot at 16-bit depth → `slot_error_o` pulses once and no bytes are written for that slot.
- **Overrun.** Hold `wr_input_FIFO_full_i`=1 across two word captures → `en` stays 0, `overrun_o`=1, the first word is held. Release `full` → only the first word's bytes are written.
- **Timeout and reset mid-word.**
  - Stop bclk for 256 clocks → `input_streaming_o` falls, pending bytes are dropped.
  - Pulse `reset_n_i` low mid-word → all outputs go to 0.
  - Resume the stream → the block re-aligns on the left channel.
